// File: rtl/rsa_job_ctrl.sv
// Job sequencer for the modular-exponentiation engine: key storage, operand snapshot,
// range/timeout checking and a valid/ready result stream.
module rsa_job_ctrl #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 key_we,
    input  logic [1:0]           key_sel,
    input  logic [2*WIDTH-1:0]   key_wdata,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2*WIDTH-1:0]   in_data,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_data,
    output logic [1:0]           out_err,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   eng_base,
    output logic [2*WIDTH-1:0]   eng_modulo,
    output logic [2*WIDTH-1:0]   eng_exponent,
    output logic                 eng_run,
    input  logic                 eng_finish,
    input  logic [2*WIDTH-1:0]   eng_result
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrRange   = 2'd1;
    localparam logic [1:0] ErrTimeout = 2'd2;

    typedef enum logic [1:0] {StIdle, StLoad, StRun, StOut} state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   n_q, e_q, d_q;
    logic [DW-1:0]   base_q, base_d;
    logic [DW-1:0]   mod_q, mod_d;
    logic [DW-1:0]   exp_q, exp_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [1:0]      out_err_q, out_err_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            range_bad;

    // Key registers are writable at any time; jobs only see them through the operand snapshot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            n_q <= '0;
            e_q <= '0;
            d_q <= '0;
        end else if (key_we) begin
            if (key_sel == 2'd0) n_q <= key_wdata;
            if (key_sel == 2'd1) e_q <= key_wdata;
            if (key_sel == 2'd2) d_q <= key_wdata;
        end
    end

    // The engine works on WIDTH-bit moduli; the upper half of n must be clear.
    assign range_bad = (n_q < DW'(2)) || (n_q[DW-1:WIDTH] != '0) || (in_data >= n_q);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        mod_d      = mod_q;
        exp_d      = exp_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        timer_d    = timer_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (range_bad) begin
                        out_data_d = '0;
                        out_err_d  = ErrRange;
                        state_d    = StOut;
                    end else begin
                        base_d  = in_data;
                        mod_d   = n_q;
                        exp_d   = in_mode ? d_q : e_q;
                        state_d = StLoad;
                    end
                end
            end
            StLoad: begin
                timer_d = '0;
                state_d = StRun;
            end
            StRun: begin
                if (eng_finish) begin
                    out_data_d = eng_result;
                    out_err_d  = ErrOk;
                    state_d    = StOut;
                end else if (timer_q == TimerLast) begin
                    out_data_d = '0;
                    out_err_d  = ErrTimeout;
                    state_d    = StOut;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StOut: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            base_q     <= '0;
            mod_q      <= '0;
            exp_q      <= '0;
            out_data_q <= '0;
            out_err_q  <= ErrOk;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            mod_q      <= mod_d;
            exp_q      <= exp_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
            timer_q    <= timer_d;
        end
    end

    // Outputs decode straight from state so an asynchronous reset drops them at once.
    assign in_ready     = (state_q == StIdle);
    assign out_valid    = (state_q == StOut);
    assign busy         = (state_q != StIdle);
    assign eng_run      = (state_q == StRun);
    assign out_data     = out_data_q;
    assign out_err      = out_err_q;
    assign eng_base     = base_q;
    assign eng_modulo   = mod_q;
    assign eng_exponent = exp_q;

endmodule
